// File: rtl/vio_databus_arbiter.sv
// vio_databus_arbiter
//  Shares one native external databus between N_PORTS versat IO units.
//  Round-robin grant, with at most MAX_BURST back-to-back beats per grant.
//  No data storage: the shared-bus request is muxed from the registered owner.
// Ports
//  clk, rst          clock, asynchronous active-low reset
//  s_valid/s_addr/   per-port native request (port i = bit/slice i)
//  s_wdata/s_wstrb   strobes all zero = read
//  s_ready           per-port completion pulse
//  s_rdata           read data broadcast to every port
//  m_*               shared native bus towards system memory
//  grant             one-hot registered owner, 0 when idle
//  busy              1 while a port owns the bus

`ifndef IO_ADDR_W
`define IO_ADDR_W 32
`endif

// Per-port payload gate: a lane drives its payload only when it owns the bus,
// so the lanes can simply be OR-ed together (one-hot AND-OR mux).
module vio_dba_lane #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int STRB_W = DATA_W/8
) (
   input  logic              sel,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [STRB_W-1:0] wstrb,
   output logic [ADDR_W-1:0] addr_g,
   output logic [DATA_W-1:0] wdata_g,
   output logic [STRB_W-1:0] wstrb_g
);
   assign addr_g  = addr  & {ADDR_W{sel}};
   assign wdata_g = wdata & {DATA_W{sel}};
   assign wstrb_g = wstrb & {STRB_W{sel}};
endmodule

module vio_databus_arbiter #(
   parameter int N_PORTS   = 4,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = `IO_ADDR_W,
   parameter int MAX_BURST = 16,
   localparam int STRB_W   = DATA_W/8,
   localparam int PTR_W    = $clog2(N_PORTS),
   localparam int CNT_W    = $clog2(MAX_BURST)+1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_PORTS-1:0]          s_valid,
   input  logic [N_PORTS*ADDR_W-1:0]   s_addr,
   input  logic [N_PORTS*DATA_W-1:0]   s_wdata,
   input  logic [N_PORTS*STRB_W-1:0]   s_wstrb,
   output logic [N_PORTS-1:0]          s_ready,
   output logic [DATA_W-1:0]           s_rdata,
   output logic                        m_valid,
   output logic [ADDR_W-1:0]           m_addr,
   output logic [DATA_W-1:0]           m_wdata,
   output logic [STRB_W-1:0]           m_wstrb,
   input  logic                        m_ready,
   input  logic [DATA_W-1:0]           m_rdata,
   output logic [N_PORTS-1:0]          grant,
   output logic                        busy
);

   typedef enum logic {IDLE, GRANTED} state_t;

   state_t               state_q, state_d;
   logic [N_PORTS-1:0]   grant_q, grant_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [N_PORTS-1:0][ADDR_W-1:0] lane_addr;
   logic [N_PORTS-1:0][DATA_W-1:0] lane_wdata;
   logic [N_PORTS-1:0][STRB_W-1:0] lane_wstrb;

   logic beat;
   int   g_idx;
   int   g_next;

   // First requester at or after 'start', wrapping; bit N_PORTS flags a hit.
   function automatic logic [N_PORTS:0] rr_pick(input logic [N_PORTS-1:0] req,
                                                 input int start);
      logic [N_PORTS:0] r;
      int idx;
      r = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         idx = (start + k) % N_PORTS;
         if (!r[N_PORTS] && req[idx]) begin
            r[N_PORTS] = 1'b1;
            r[idx]     = 1'b1;
         end
      end
      return r;
   endfunction

   for (genvar i = 0; i < N_PORTS; i++) begin : g_lane
      vio_dba_lane #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) u_lane (
         .sel     (grant_q[i]),
         .addr    (s_addr[i*ADDR_W +: ADDR_W]),
         .wdata   (s_wdata[i*DATA_W +: DATA_W]),
         .wstrb   (s_wstrb[i*STRB_W +: STRB_W]),
         .addr_g  (lane_addr[i]),
         .wdata_g (lane_wdata[i]),
         .wstrb_g (lane_wstrb[i])
      );
   end

   always_comb begin
      m_addr  = '0;
      m_wdata = '0;
      m_wstrb = '0;
      g_idx   = 0;
      for (int i = 0; i < N_PORTS; i++) begin
         m_addr  = m_addr  | lane_addr[i];
         m_wdata = m_wdata | lane_wdata[i];
         m_wstrb = m_wstrb | lane_wstrb[i];
         if (grant_q[i]) g_idx = i;
      end
      g_next = (g_idx + 1) % N_PORTS;
   end

   // grant_q is zero when idle or in reset, so m_valid drops with it.
   assign m_valid = |(s_valid & grant_q);
   assign beat    = m_valid & m_ready;
   assign s_ready = grant_q & {N_PORTS{beat}};
   assign s_rdata = m_rdata;
   assign grant   = grant_q;
   assign busy    = (state_q == GRANTED);

   always_comb begin
      logic [N_PORTS:0] pick;
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      pick    = '0;
      case (state_q)
         IDLE: begin
            pick = rr_pick(s_valid, int'(ptr_q));
            if (pick[N_PORTS]) begin
               grant_d = pick[N_PORTS-1:0];
               cnt_d   = '0;
               state_d = GRANTED;
            end
         end
         GRANTED: begin
            if (beat && (cnt_q < CNT_W'(MAX_BURST-1))) begin
               // Hold the grant; next cycle's s_valid decides whether the
               // owner continues or the grant ends through the abort path.
               cnt_d = cnt_q + CNT_W'(1);
            end else if (beat || !m_valid) begin
               // Search starts after g and wraps onto g last, so a lone
               // owner that hit the burst limit is simply re-granted.
               pick  = rr_pick(s_valid, g_next);
               ptr_d = PTR_W'(g_next);
               cnt_d = '0;
               if (pick[N_PORTS]) begin
                  grant_d = pick[N_PORTS-1:0];
               end else begin
                  grant_d = '0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_vio_databus_arbiter.sv
// Directed bench for vio_databus_arbiter (4 ports, MAX_BURST=4, 16-bit addr).
module tb_vio_databus_arbiter;
   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        s_valid;
   logic [3:0][15:0]  s_addr;
   logic [3:0][31:0]  s_wdata;
   logic [3:0][3:0]   s_wstrb;
   logic [3:0]        s_ready;
   logic [31:0]       s_rdata;
   logic              m_valid;
   logic [15:0]       m_addr;
   logic [31:0]       m_wdata;
   logic [3:0]        m_wstrb;
   logic              m_ready;
   logic [31:0]       m_rdata;
   logic [3:0]        grant;
   logic              busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   vio_databus_arbiter #(.N_PORTS(4), .DATA_W(32), .ADDR_W(16), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_ready(s_ready), .s_rdata(s_rdata),
      .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_ready(m_ready), .m_rdata(m_rdata),
      .grant(grant), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      s_valid = '0;
      m_ready = 1'b0;
      rst     = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   logic [3:0] seq3 [12];

   initial begin
      rst     = 1'b0;
      s_valid = '0;
      s_addr  = '0;
      s_wdata = '0;
      s_wstrb = '0;
      m_ready = 1'b0;
      m_rdata = '0;
      #2;
      chk("rst_grant",   grant,   4'b0000);
      chk("rst_busy",    busy,    1'b0);
      chk("rst_mvalid",  m_valid, 1'b0);
      chk("rst_sready",  s_ready, 4'b0000);
      tick();
      tick();
      rst = 1'b1;

      // 1: single read on port 2, m_ready after 3 cycles
      s_addr[2] = 16'h2222;
      s_valid   = 4'b0100;
      #1;
      chk("t1_latency_mvalid", m_valid, 1'b0);
      tick();
      chk("t1_grant",  grant,   4'b0100);
      chk("t1_busy",   busy,    1'b1);
      chk("t1_mvalid", m_valid, 1'b1);
      chk("t1_maddr",  m_addr,  16'h2222);
      chk("t1_mwstrb", m_wstrb, 4'h0);
      chk("t1_noready", s_ready, 4'b0000);
      tick();
      tick();
      m_ready = 1'b1;
      m_rdata = 32'hDEADBEEF;
      #1;
      chk("t1_sready", s_ready, 4'b0100);
      chk("t1_rdata",  s_rdata, 32'hDEADBEEF);
      tick();
      s_valid = '0;
      m_ready = 1'b0;
      #1;
      chk("t1_one_pulse", s_ready, 4'b0000);
      tick();
      chk("t1_idle_grant", grant, 4'b0000);
      chk("t1_idle_busy",  busy,  1'b0);

      // 2: ports 0 and 1 together after reset
      do_reset();
      s_addr[0] = 16'h0A00;
      s_addr[1] = 16'h0A11;
      s_valid   = 4'b0011;
      m_ready   = 1'b1;
      tick();
      chk("t2_first_grant", grant,   4'b0001);
      chk("t2_first_addr",  m_addr,  16'h0A00);
      chk("t2_first_ready", s_ready, 4'b0001);
      tick();
      s_valid = 4'b0010;
      #1;
      chk("t2_gap_grant", grant, 4'b0001);
      chk("t2_gap_busy",  busy,  1'b1);
      tick();
      chk("t2_second_grant", grant,   4'b0010);
      chk("t2_second_addr",  m_addr,  16'h0A11);
      chk("t2_second_ready", s_ready, 4'b0010);
      tick();
      s_valid = '0;
      tick();
      chk("t2_idle", grant, 4'b0000);

      // 3: ports 0 and 3 saturating, MAX_BURST=4
      seq3 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
               4'b1000, 4'b1000, 4'b1000, 4'b1000,
               4'b0001, 4'b0001, 4'b0001, 4'b0001};
      do_reset();
      s_valid = 4'b1001;
      m_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk($sformatf("t3_grant_%0d", i), grant,   seq3[i]);
         chk($sformatf("t3_ready_%0d", i), s_ready, seq3[i]);
      end
      s_valid = '0;
      m_ready = 1'b0;

      // 4: port 1 write stalled for 10 cycles
      do_reset();
      s_addr[1]  = 16'h0B11;
      s_wdata[1] = 32'h12345678;
      s_wstrb[1] = 4'hF;
      s_valid    = 4'b0010;
      tick();
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("t4_grant_%0d", i), grant,   4'b0010);
         chk($sformatf("t4_ready_%0d", i), s_ready, 4'b0000);
         chk($sformatf("t4_addr_%0d", i),  m_addr,  16'h0B11);
         chk($sformatf("t4_wdata_%0d", i), m_wdata, 32'h12345678);
         chk($sformatf("t4_wstrb_%0d", i), m_wstrb, 4'hF);
         tick();
      end
      m_ready = 1'b1;
      #1;
      chk("t4_release_ready", s_ready, 4'b0010);
      tick();
      s_valid = '0;
      m_ready = 1'b0;

      // 5: reset mid-burst restores pointer 0
      do_reset();
      s_valid = 4'b0001;
      m_ready = 1'b1;
      tick();
      tick();
      s_valid = '0;
      tick();
      chk("t5_idle", grant, 4'b0000);
      s_valid = 4'b0101;
      tick();
      chk("t5_ptr1_grant", grant, 4'b0100);
      tick();
      rst = 1'b0;
      #1;
      chk("t5_rst_grant",  grant,   4'b0000);
      chk("t5_rst_mvalid", m_valid, 1'b0);
      chk("t5_rst_busy",   busy,    1'b0);
      chk("t5_rst_sready", s_ready, 4'b0000);
      tick();
      rst = 1'b1;
      tick();
      chk("t5_after_grant", grant, 4'b0001);
      s_valid = '0;
      m_ready = 1'b0;

      // 6: owner port 3 aborts while port 1 waits
      do_reset();
      s_valid = 4'b1000;
      tick();
      chk("t6_grant3", grant, 4'b1000);
      s_valid = 4'b1010;
      tick();
      chk("t6_hold3", grant, 4'b1000);
      s_valid = 4'b0010;
      #1;
      chk("t6_abort_mvalid", m_valid, 1'b0);
      chk("t6_abort_ready",  s_ready, 4'b0000);
      tick();
      chk("t6_grant1",  grant,   4'b0010);
      chk("t6_noready", s_ready, 4'b0000);
      m_ready = 1'b1;
      #1;
      chk("t6_ready1", s_ready, 4'b0010);
      tick();
      s_valid = '0;
      m_ready = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
